mem_access_master: RTL and testbench

- CPU-side initiator for the dual-port word memory: converts instruction-fetch and load/store requests into the memory's readM1/address1/data1 and readM2/writeM2/address2/data2 signalling.
- Owns memory-side timing: registered read latency, tri-state ownership of data2, write strobes.
- Sits between the CPU datapath/control and the memory at top level.
- Fetch channel and data channel are independent and may be busy concurrently.

---
 rtl/mem_access_master.sv | 146 ++++++++++++++
 tb/tb_mem_access_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_master.sv
// CPU-side initiator for the dual-port word memory: an instruction-fetch channel on
// port 1 and an independent load/store channel on port 2, both with two-cycle reads.
module mem_access_master #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic                  if_valid,
  output logic [WORD_SIZE-1:0]  if_data,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_SIZE-1:0]  d_wdata,
  output logic                  d_ready,
  output logic                  d_done,
  output logic [WORD_SIZE-1:0]  d_rdata,
  output logic                  readM1,
  output logic [ADDR_WIDTH-1:0] address1,
  input  logic [WORD_SIZE-1:0]  data1,
  output logic                  readM2,
  output logic                  writeM2,
  output logic [ADDR_WIDTH-1:0] address2,
  inout  wire  [WORD_SIZE-1:0]  data2
);

  typedef enum logic [1:0] {F_IDLE, F_ADDR, F_DATA} f_state_e;
  typedef enum logic [1:0] {D_IDLE, D_RADDR, D_RDATA, D_WRITE} d_state_e;

  f_state_e              f_state_q;
  logic                  readM1_q;
  logic                  if_valid_q;
  logic [ADDR_WIDTH-1:0] address1_q;
  logic [WORD_SIZE-1:0]  if_data_q;

  d_state_e              d_state_q;
  logic                  readM2_q;
  logic                  writeM2_q;
  logic                  d_done_q;
  logic [ADDR_WIDTH-1:0] address2_q;
  logic [WORD_SIZE-1:0]  d_rdata_q;
  logic [WORD_SIZE-1:0]  wdata_q;

  logic                  if_accept;
  logic                  d_accept;

  // Ready depends on state only, so no CPU input reaches the memory pins combinationally.
  assign if_ready  = (f_state_q != F_ADDR);
  assign d_ready   = (d_state_q != D_RADDR);
  assign if_accept = if_req & if_ready;
  assign d_accept  = d_req & d_ready;

  assign readM1   = readM1_q;
  assign address1 = address1_q;
  assign if_valid = if_valid_q;
  assign if_data  = if_data_q;
  assign readM2   = readM2_q;
  assign writeM2  = writeM2_q;
  assign address2 = address2_q;
  assign d_done   = d_done_q;
  assign d_rdata  = d_rdata_q;

  // The bus is driven only during the single write cycle, when readM2 is guaranteed low.
  assign data2 = writeM2_q ? wdata_q : {WORD_SIZE{1'bz}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_state_q  <= F_IDLE;
      readM1_q   <= 1'b0;
      address1_q <= '0;
      if_data_q  <= '0;
      if_valid_q <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      case (f_state_q)
        F_ADDR: f_state_q <= F_DATA;
        default: begin
          if (f_state_q == F_DATA) begin
            if_data_q  <= data1;
            if_valid_q <= 1'b1;
          end
          if (if_accept) begin
            f_state_q  <= F_ADDR;
            readM1_q   <= 1'b1;
            address1_q <= if_addr;
          end else begin
            f_state_q  <= F_IDLE;
            readM1_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_state_q  <= D_IDLE;
      readM2_q   <= 1'b0;
      writeM2_q  <= 1'b0;
      address2_q <= '0;
      d_rdata_q  <= '0;
      d_done_q   <= 1'b0;
    end else begin
      d_done_q <= 1'b0;
      case (d_state_q)
        D_RADDR: d_state_q <= D_RDATA;
        default: begin
          if (d_state_q == D_RDATA) begin
            d_rdata_q <= data2;
            d_done_q  <= 1'b1;
          end
          if (d_state_q == D_WRITE) begin
            d_done_q <= 1'b1;
          end
          if (d_accept) begin
            address2_q <= d_addr;
            if (d_we) begin
              d_state_q <= D_WRITE;
              readM2_q  <= 1'b0;
              writeM2_q <= 1'b1;
            end else begin
              d_state_q <= D_RADDR;
              readM2_q  <= 1'b1;
              writeM2_q <= 1'b0;
            end
          end else begin
            d_state_q <= D_IDLE;
            readM2_q  <= 1'b0;
            writeM2_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Store data is only meaningful while writeM2 is high, so it needs no reset.
  always_ff @(posedge clk) begin
    if (d_accept) begin
      wdata_q <= d_wdata;
    end
  end

endmodule

// File: tb/tb_mem_access_master.sv
// Scoreboard bench for mem_access_master with a behavioural dual-port memory that
// latches read data on strobed edges and forwards same-edge store data to port 1.
module tb_mem_access_master;

  localparam int WS = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_ready, if_valid;
  logic [AW-1:0] if_addr;
  logic [WS-1:0] if_data;
  logic          d_req, d_we, d_ready, d_done;
  logic [AW-1:0] d_addr;
  logic [WS-1:0] d_wdata, d_rdata;
  logic          readM1, readM2, writeM2;
  logic [AW-1:0] address1, address2;
  logic [WS-1:0] data1;
  wire  [WS-1:0] data2;

  mem_access_master #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_done(d_done), .d_rdata(d_rdata),
    .readM1(readM1), .address1(address1), .data1(data1),
    .readM2(readM2), .writeM2(writeM2), .address2(address2), .data2(data2)
  );

  always #5 clk = ~clk;

  // Behavioural memory
  logic          mem_load;
  logic [WS-1:0] mem [0:255];
  logic [WS-1:0] rd1_q, rd2_q;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] = WS'(i * 7 + 16'h0100);
      mem[8'h00] = 16'h9023;
      mem[8'h23] = 16'h6000;
      mem[8'h24] = 16'hf01c;
    end else begin
      if (readM1) rd1_q <= (writeM2 && address2 == address1) ? data2 : mem[address1[7:0]];
      if (readM2) rd2_q <= mem[address2[7:0]];
      if (writeM2) mem[address2[7:0]] = data2;
    end
  end

  assign data1 = readM1 ? rd1_q : 16'hDEAD;
  assign data2 = readM2 ? rd2_q : {WS{1'bz}};

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct packed {
    logic          ld;
    logic [WS-1:0] val;
    int            acc;
  } dexp_t;

  logic [WS-1:0] if_exp_q[$];
  int            if_acc_q[$];
  dexp_t         d_exp_q[$];
  logic [WS-1:0] last_load = '0;
  logic [WS-1:0] wr_exp = '0;
  int            cyc = 0;
  int            n_ifv = 0, n_ddone = 0, n_wr = 0;
  logic [WS-1:0] mon_if_e;
  int            mon_if_a;
  dexp_t         mon_d_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if_valid) begin
      n_ifv++;
      if (if_exp_q.size() == 0) chk("if_spurious", if_valid, 1'b0);
      else begin
        mon_if_e = if_exp_q.pop_front();
        mon_if_a = if_acc_q.pop_front();
        chk("if_data", if_data, mon_if_e);
        chk("if_latency", cyc - mon_if_a, 3);
      end
    end
    if (d_done) begin
      n_ddone++;
      if (d_exp_q.size() == 0) chk("d_spurious", d_done, 1'b0);
      else begin
        mon_d_e = d_exp_q.pop_front();
        if (mon_d_e.ld) begin
          chk("d_rdata", d_rdata, mon_d_e.val);
          chk("ld_latency", cyc - mon_d_e.acc, 3);
          last_load = mon_d_e.val;
        end else begin
          chk("d_rdata_hold", d_rdata, last_load);
          chk("st_latency", cyc - mon_d_e.acc, 2);
        end
      end
    end
    if (writeM2) begin
      n_wr++;
      chk("rw_exclusive", readM2, 1'b0);
      chk("wr_bus_data", data2, wr_exp);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_if_ready();
    int n = 0;
    @(negedge clk);
    while (!if_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("if_ready_timeout", if_ready, 1'b1);
  endtask

  task automatic wait_d_ready();
    int n = 0;
    @(negedge clk);
    while (!d_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("d_ready_timeout", d_ready, 1'b1);
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [WS-1:0] e);
    if_req = 1'b1; if_addr = a;
    wait_if_ready();
    if_exp_q.push_back(e); if_acc_q.push_back(cyc);
    step(1);
    if_req = 1'b0;
  endtask

  task automatic daccess(input logic we, input logic [AW-1:0] a, input logic [WS-1:0] wd,
                         input logic [WS-1:0] e);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    if (we) wr_exp = wd;
    wait_d_ready();
    d_exp_q.push_back('{ld: !we, val: e, acc: cyc});
    step(1);
    d_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, a1, v0, d0;
    reset = 1'b0; mem_load = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #1 reset = 1'b1;
    step(3);
    chk("rst_strobes", {readM1, readM2, writeM2, if_valid, d_done}, 5'b0);
    chk("rst_addr", {address1, address2}, 32'h0);
    chk("rst_data", {if_data, d_rdata}, 32'h0);
    mem_load = 1'b0; reset = 1'b0;
    #1 chk("rst_ready", {if_ready, d_ready}, 2'b11);

    // Single fetch from address 0
    fetch(16'h0000, 16'h9023);
    chk("t1_readM1_addr", readM1, 1'b1);
    chk("t1_address1", address1, 16'h0000);
    chk("t1_ready_in_addr", if_ready, 1'b0);
    step(1);
    chk("t1_readM1_data", readM1, 1'b1);
    chk("t1_ready_in_data", if_ready, 1'b1);
    step(1);
    chk("t1_readM1_off", readM1, 1'b0);
    step(2);

    // Back-to-back fetches with if_req held
    if_req = 1'b1; if_addr = 16'h0023;
    wait_if_ready();
    a0 = cyc; if_exp_q.push_back(16'h6000); if_acc_q.push_back(cyc);
    step(1);
    if_addr = 16'h0024;
    chk("b2b_ready_low", if_ready, 1'b0);
    wait_if_ready();
    a1 = cyc; if_exp_q.push_back(16'hf01c); if_acc_q.push_back(cyc);
    chk("b2b_accept_gap", a1 - a0, 2);
    step(1);
    if_req = 1'b0;
    step(4);

    // Store then load
    daccess(1'b1, 16'h00F0, 16'hBEEF, 16'h0);
    chk("st_writeM2", writeM2, 1'b1);
    chk("st_readM2", readM2, 1'b0);
    chk("st_address2", address2, 16'h00F0);
    step(1);
    chk("st_one_cycle", writeM2, 1'b0);
    daccess(1'b0, 16'h00F0, 16'h0, 16'hBEEF);
    chk("ld_readM2", readM2, 1'b1);
    step(4);

    // Concurrent fetch and store to the same address
    v0 = n_ifv; d0 = n_ddone;
    if_req = 1'b1; if_addr = 16'h0050;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0050; d_wdata = 16'h1234; wr_exp = 16'h1234;
    @(negedge clk);
    chk("cc_both_ready", {if_ready, d_ready}, 2'b11);
    if_exp_q.push_back(16'h1234); if_acc_q.push_back(cyc);
    d_exp_q.push_back('{ld: 1'b0, val: 16'h0, acc: cyc});
    step(1);
    if_req = 1'b0; d_req = 1'b0;
    step(6);
    chk("cc_ifvalid_once", n_ifv - v0, 1);
    chk("cc_ddone_once", n_ddone - d0, 1);

    // Reset during D_RDATA and F_ADDR
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0023;
    wait_d_ready();
    step(1);
    d_req = 1'b0; if_req = 1'b1; if_addr = 16'h0024;
    step(1);
    if_req = 1'b0;
    chk("mid_strobes_up", {readM1, readM2}, 2'b11);
    v0 = n_ifv; d0 = n_ddone;
    reset = 1'b1;
    #1;
    chk("mid_rst_strobes", {readM1, readM2, writeM2, if_valid, d_done}, 5'b0);
    chk("mid_rst_addr", {address1, address2}, 32'h0);
    chk("mid_rst_data", {if_data, d_rdata}, 32'h0);
    last_load = '0;
    step(3);
    reset = 1'b0;
    #1 chk("mid_rel_ready", {if_ready, d_ready}, 2'b11);
    step(3);
    chk("mid_no_pulses", {n_ifv - v0, n_ddone - d0}, 64'h0);
    daccess(1'b0, 16'h00F0, 16'h0, 16'hBEEF);
    step(4);

    // Store chained directly into a load
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0060; d_wdata = 16'h5A5A; wr_exp = 16'h5A5A;
    wait_d_ready();
    d_exp_q.push_back('{ld: 1'b0, val: 16'h0, acc: cyc});
    step(1);
    d_we = 1'b0;
    wait_d_ready();
    d_exp_q.push_back('{ld: 1'b1, val: 16'h5A5A, acc: cyc});
    step(1);
    d_req = 1'b0;
    chk("chain_readM2", readM2, 1'b1);
    chk("chain_writeM2", writeM2, 1'b0);
    step(6);

    chk("if_queue_empty", if_exp_q.size(), 0);
    chk("d_queue_empty", d_exp_q.size(), 0);
    chk("write_cycles", n_wr, 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
